// File: rtl/xo_decode_stage_if.sv
// Handshake bundle between fetch/issue, the XO decode stage and dispatch.
// Upstream instruction beat and downstream decode packet, each valid/ready.
interface xo_decode_stage_if #(
    parameter int instructionWidth = 32,
    parameter int regWidth         = 5,
    parameter int XoOpCodeWidth    = 9,
    parameter int tagWidth         = 8
) ();
    logic                        valid_i;
    logic                        ready_o;
    logic [instructionWidth-1:0] instruction_i;
    logic [tagWidth-1:0]         tag_i;

    logic                        valid_o;
    logic                        ready_i;
    logic [tagWidth-1:0]         tag_o;
    logic [regWidth-1:0]         reg1_o;
    logic [regWidth-1:0]         reg2_o;
    logic [regWidth-1:0]         reg3_o;
    logic [XoOpCodeWidth-1:0]    xOpCode_o;
    logic                        oe_o;
    logic                        rc_o;
    logic                        useRb_o;
    logic                        readsCa_o;
    logic                        writesCa_o;
    logic [1:0]                  execClass_o;
    logic [2:0]                  functionalUnitCode_o;

    modport master (
        output valid_i, instruction_i, tag_i, ready_i,
        input  ready_o, valid_o, tag_o, reg1_o, reg2_o, reg3_o,
        input  xOpCode_o, oe_o, rc_o, useRb_o, readsCa_o,
        input  writesCa_o, execClass_o, functionalUnitCode_o
    );

    modport slave (
        input  valid_i, instruction_i, tag_i, ready_i,
        output ready_o, valid_o, tag_o, reg1_o, reg2_o, reg3_o,
        output xOpCode_o, oe_o, rc_o, useRb_o, readsCa_o,
        output writesCa_o, execClass_o, functionalUnitCode_o
    );
endinterface

// File: rtl/xo_decode_stage.sv
// Pipelined XO-form decoder with a 2-entry skid buffer.
// Output register plus skid register keep 1 instr/cycle under back-pressure.
module xo_decode_stage #(
    parameter int instructionWidth = 32,
    parameter int regWidth         = 5,
    parameter int XoOpCodeWidth    = 9,
    parameter int tagWidth         = 8,
    parameter int countWidth       = 16,
    parameter int support64        = 1,
    parameter int FXUnitCode       = 0,
    parameter int MulDivUnitCode   = 5
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    xo_decode_stage_if.slave      bus,
    output logic                  unrecognised_o,
    output logic [countWidth-1:0] decodeCount_o
);
    localparam int IW = instructionWidth;

    typedef struct packed {
        logic [tagWidth-1:0]      tag;
        logic [regWidth-1:0]      reg1;
        logic [regWidth-1:0]      reg2;
        logic [regWidth-1:0]      reg3;
        logic [XoOpCodeWidth-1:0] xop;
        logic                     oe;
        logic                     rc;
        logic                     use_rb;
        logic                     reads_ca;
        logic                     writes_ca;
        logic [1:0]               exec_class;
        logic [2:0]               unit;
    } pkt_t;

    pkt_t out_q;
    pkt_t skid_q;
    pkt_t dec_pkt;
    logic out_valid_q;
    logic skid_valid_q;
    logic unrec_q;

    logic [5:0]               prim_op;
    logic [XoOpCodeWidth-1:0] xo;
    logic                     known;
    logic                     dword;
    logic                     use_rb;
    logic                     rd_ca;
    logic                     wr_ca;
    logic                     oe_kill;
    logic                     rc_kill;
    logic [1:0]               cls;
    logic [2:0]               unit;
    logic                     is31;
    logic                     recognised;
    logic                     accept;
    logic                     dec_valid;
    logic                     load_out;

    assign prim_op = bus.instruction_i[IW-1 -: 6];
    assign xo      = bus.instruction_i[IW-23 -: XoOpCodeWidth];

    // Classify the extended opcode into operand usage, carry and unit.
    always_comb begin
        known   = 1'b1;
        dword   = 1'b0;
        use_rb  = 1'b1;
        rd_ca   = 1'b0;
        wr_ca   = 1'b0;
        oe_kill = 1'b0;
        rc_kill = 1'b0;
        cls     = 2'd0;
        unit    = 3'(FXUnitCode);
        case (int'(xo))
            266, 40: ;
            10, 8: wr_ca = 1'b1;
            138, 136: begin
                rd_ca = 1'b1;
                wr_ca = 1'b1;
            end
            234, 232, 202, 200: begin
                use_rb = 1'b0;
                rd_ca  = 1'b1;
                wr_ca  = 1'b1;
            end
            104: use_rb = 1'b0;
            235: begin
                cls  = 2'd1;
                unit = 3'(MulDivUnitCode);
            end
            75, 11: begin
                cls     = 2'd1;
                unit    = 3'(MulDivUnitCode);
                oe_kill = 1'b1;
            end
            233: begin
                cls   = 2'd1;
                unit  = 3'(MulDivUnitCode);
                dword = 1'b1;
            end
            73, 9: begin
                cls     = 2'd1;
                unit    = 3'(MulDivUnitCode);
                dword   = 1'b1;
                oe_kill = 1'b1;
            end
            491, 459, 427, 395: begin
                cls  = 2'd2;
                unit = 3'(MulDivUnitCode);
            end
            489, 457, 425, 393: begin
                cls   = 2'd2;
                unit  = 3'(MulDivUnitCode);
                dword = 1'b1;
            end
            74: begin
                cls     = 2'd3;
                oe_kill = 1'b1;
                rc_kill = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    assign is31       = (prim_op == 6'd31);
    assign recognised = known && (!dword || (support64 != 0));
    assign accept     = bus.valid_i && bus.ready_o && !flush_i;
    assign dec_valid  = accept && is31 && recognised;
    assign load_out   = !out_valid_q || bus.ready_i;

    // Assemble the packet for the word presented this cycle.
    always_comb begin
        dec_pkt            = '0;
        dec_pkt.tag        = bus.tag_i;
        dec_pkt.reg1       = bus.instruction_i[IW-7 -: regWidth];
        dec_pkt.reg2       = bus.instruction_i[IW-12 -: regWidth];
        dec_pkt.reg3       = bus.instruction_i[IW-17 -: regWidth];
        dec_pkt.xop        = xo;
        dec_pkt.oe         = bus.instruction_i[IW-22] && !oe_kill;
        dec_pkt.rc         = bus.instruction_i[IW-32] && !rc_kill;
        dec_pkt.use_rb     = use_rb;
        dec_pkt.reads_ca   = rd_ca;
        dec_pkt.writes_ca  = wr_ca;
        dec_pkt.exec_class = cls;
        dec_pkt.unit       = unit;
    end

    // Output/skid registers; skid drains first to keep acceptance order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            unrec_q      <= 1'b0;
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            unrec_q      <= 1'b0;
        end else begin
            unrec_q <= accept && is31 && !recognised;
            if (load_out) begin
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= dec_valid;
                    if (dec_valid) out_q <= dec_pkt;
                end
            end else if (dec_valid) begin
                skid_q       <= dec_pkt;
                skid_valid_q <= 1'b1;
            end
        end
    end

    // Count emitted packets, including one handshaken during a flush.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            decodeCount_o <= '0;
        end else if (out_valid_q && bus.ready_i) begin
            decodeCount_o <= decodeCount_o + countWidth'(1);
        end
    end

    assign bus.ready_o              = !skid_valid_q;
    assign bus.valid_o              = out_valid_q;
    assign bus.tag_o                = out_q.tag;
    assign bus.reg1_o               = out_q.reg1;
    assign bus.reg2_o               = out_q.reg2;
    assign bus.reg3_o               = out_q.reg3;
    assign bus.xOpCode_o            = out_q.xop;
    assign bus.oe_o                 = out_q.oe;
    assign bus.rc_o                 = out_q.rc;
    assign bus.useRb_o              = out_q.use_rb;
    assign bus.readsCa_o            = out_q.reads_ca;
    assign bus.writesCa_o           = out_q.writes_ca;
    assign bus.execClass_o          = out_q.exec_class;
    assign bus.functionalUnitCode_o = out_q.unit;
    assign unrecognised_o           = unrec_q;
endmodule

// File: tb/tb_xo_decode_stage.sv
// Bench for xo_decode_stage: a 64-bit/16-bit-count instance and a
// 32-bit/4-bit-count instance against a queue-based reference model.
module tb_xo_decode_stage;
    typedef struct packed {
        logic [7:0] tag;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] r3;
        logic [8:0] xop;
        logic       oe;
        logic       rc;
        logic       urb;
        logic       rca;
        logic       wca;
        logic [1:0] cls;
        logic [2:0] unit;
    } pkt_t;

    localparam logic [31:0] ADD = 32'h7C642A14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fl  = 1'b0;
    always #5 clk = ~clk;

    xo_decode_stage_if busA ();
    xo_decode_stage_if busB ();
    logic        unA, unB;
    logic [15:0] cntA;
    logic [3:0]  cntB;

    xo_decode_stage #(.support64(1), .countWidth(16)) dutA (
        .clock_i(clk), .reset_i(rst), .flush_i(fl), .bus(busA.slave),
        .unrecognised_o(unA), .decodeCount_o(cntA)
    );
    xo_decode_stage #(.support64(0), .countWidth(4)) dutB (
        .clock_i(clk), .reset_i(rst), .flush_i(fl), .bus(busB.slave),
        .unrecognised_o(unB), .decodeCount_o(cntB)
    );

    pkt_t obsA, obsB;
    assign obsA = {busA.tag_o, busA.reg1_o, busA.reg2_o, busA.reg3_o,
                   busA.xOpCode_o, busA.oe_o, busA.rc_o, busA.useRb_o,
                   busA.readsCa_o, busA.writesCa_o, busA.execClass_o,
                   busA.functionalUnitCode_o};
    assign obsB = {busB.tag_o, busB.reg1_o, busB.reg2_o, busB.reg3_o,
                   busB.xOpCode_o, busB.oe_o, busB.rc_o, busB.useRb_o,
                   busB.readsCa_o, busB.writesCa_o, busB.execClass_o,
                   busB.functionalUnitCode_o};

    int errors = 0;
    int checks = 0;

    pkt_t mq [2][$];
    int   mcnt [2];
    bit   munr [2];

    int add_rb[$]   = '{266, 40, 10, 8, 138, 136};
    int add_norb[$] = '{234, 232, 202, 200, 104};
    int ca_in[$]    = '{138, 136, 234, 232, 202, 200};
    int mul[$]      = '{235, 75, 11, 233, 73, 9};
    int dvd[$]      = '{491, 459, 427, 395, 489, 457, 425, 393};
    int dw[$]       = '{233, 73, 9, 489, 457, 425, 393};
    int mulh[$]     = '{75, 11, 73, 9};
    int all_xo[$]   = '{266, 40, 10, 8, 138, 136, 234, 232, 202, 200,
                        104, 235, 75, 11, 233, 73, 9, 491, 459, 427,
                        395, 489, 457, 425, 393, 74};

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic bit has(input int l[$], input int v);
        foreach (l[i]) if (l[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int prim(input logic [31:0] w);
        return int'(w >> 26);
    endfunction

    // Reference decode straight from the opcode tables.
    function automatic bit ref_dec(input logic [31:0] w, input bit s64,
                                   output pkt_t p);
        int xo;
        xo    = int'((w >> 1) & 32'h1FF);
        p     = '0;
        p.r1  = 5'((w >> 21) & 32'd31);
        p.r2  = 5'((w >> 16) & 32'd31);
        p.r3  = 5'((w >> 11) & 32'd31);
        p.xop = 9'(xo);
        p.oe  = 1'((w >> 10) & 32'd1);
        p.rc  = 1'(w & 32'd1);
        if (has(add_rb, xo) || has(add_norb, xo)) begin
            p.unit = 3'd0;
            p.urb  = has(add_rb, xo);
            p.rca  = has(ca_in, xo);
            p.wca  = p.rca || xo == 10 || xo == 8;
        end else if (has(mul, xo)) begin
            p.cls  = 2'd1;
            p.unit = 3'd5;
            p.urb  = 1'b1;
        end else if (has(dvd, xo)) begin
            p.cls  = 2'd2;
            p.unit = 3'd5;
            p.urb  = 1'b1;
        end else if (xo == 74) begin
            p.cls = 2'd3;
            p.urb = 1'b1;
            p.rc  = 1'b0;
        end else begin
            return 1'b0;
        end
        if (has(mulh, xo) || xo == 74) p.oe = 1'b0;
        if (has(dw, xo) && !s64) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] rand_word();
        int          k;
        logic [31:0] w;
        k = $urandom_range(0, 9);
        w = $urandom;
        if (k == 0) begin
            if (w[31:26] == 6'd31) w[31:26] = 6'd14;
        end else begin
            w[31:26] = 6'd31;
            if (k > 1) w[9:1] = 9'(all_xo[$urandom_range(0, all_xo.size() - 1)]);
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mcnt[m] = 0;
            munr[m] = 1'b0;
        end
    endtask

    task automatic compare(input int m, input logic vo, input logic ro,
                           input logic un, input logic [15:0] c,
                           input pkt_t o);
        check($sformatf("m%0d_valid", m), 64'(vo), 64'(mq[m].size() > 0));
        if (mq[m].size() > 0)
            check($sformatf("m%0d_pkt", m), 64'(o), 64'(mq[m][0]));
        check($sformatf("m%0d_ready", m), 64'(ro), 64'(mq[m].size() < 2));
        check($sformatf("m%0d_unrec", m), 64'(un), 64'(munr[m]));
        check($sformatf("m%0d_count", m), 64'(c), 64'(mcnt[m]));
    endtask

    // Drive one cycle, advance the model, then check both instances.
    task automatic step(input bit v, input logic [31:0] w,
                        input logic [7:0] tg, input bit rdy, input bit f,
                        output bit accA);
        pkt_t p;
        bit   ok, acc;
        busA.valid_i = v;  busB.valid_i = v;
        busA.instruction_i = w;  busB.instruction_i = w;
        busA.tag_i = tg;  busB.tag_i = tg;
        busA.ready_i = rdy;  busB.ready_i = rdy;
        fl = f;
        accA = 1'b0;
        for (int m = 0; m < 2; m++) begin
            acc = v && mq[m].size() < 2 && !f;
            if (m == 0) accA = acc;
            if (mq[m].size() > 0 && rdy)
                mcnt[m] = (mcnt[m] + 1) % (m == 0 ? 65536 : 16);
            ok = ref_dec(w, m == 0, p);
            p.tag = tg;
            munr[m] = acc && prim(w) == 31 && !ok;
            if (f) begin
                mq[m].delete();
            end else begin
                if (mq[m].size() > 0 && rdy) void'(mq[m].pop_front());
                if (acc && prim(w) == 31 && ok) mq[m].push_back(p);
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare(0, busA.valid_o, busA.ready_o, unA, 16'(cntA), obsA);
        compare(1, busB.valid_o, busB.ready_o, unB, 16'(cntB), obsB);
    endtask

    task automatic idle();
        bit a;
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, a);
    endtask

    initial begin
        bit     a;
        int     sent;
        int     c0;
        logic [7:0] got[$];
        busA.valid_i = 1'b0;  busB.valid_i = 1'b0;
        busA.instruction_i = '0;  busB.instruction_i = '0;
        busA.tag_i = '0;  busB.tag_i = '0;
        busA.ready_i = 1'b1;  busB.ready_i = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare(0, busA.valid_o, busA.ready_o, unA, 16'(cntA), obsA);
        compare(1, busB.valid_o, busB.ready_o, unB, 16'(cntB), obsB);
        check("rst_pktA", 64'(obsA), 64'd0);
        check("rst_pktB", 64'(obsB), 64'd0);

        step(1'b1, ADD, 8'h11, 1'b1, 1'b0, a);
        check("add_valid", 64'(busA.valid_o), 64'd1);
        check("add_r1", 64'(busA.reg1_o), 64'd3);
        check("add_r2", 64'(busA.reg2_o), 64'd4);
        check("add_r3", 64'(busA.reg3_o), 64'd5);
        check("add_xop", 64'(busA.xOpCode_o), 64'd266);
        check("add_cls", 64'(busA.execClass_o), 64'd0);
        check("add_urb", 64'(busA.useRb_o), 64'd1);
        check("add_wca", 64'(busA.writesCa_o), 64'd0);
        idle();
        check("add_cnt", 64'(cntA), 64'd1);

        step(1'b1, 32'h7CC70195, 8'h12, 1'b1, 1'b0, a);
        check("addze_rc", 64'(busA.rc_o), 64'd1);
        check("addze_urb", 64'(busA.useRb_o), 64'd0);
        check("addze_rca", 64'(busA.readsCa_o), 64'd1);
        check("addze_wca", 64'(busA.writesCa_o), 64'd1);
        check("addze_unit", 64'(busA.functionalUnitCode_o), 64'd0);
        idle();

        step(1'b1, 32'h7C2213D2, 8'h13, 1'b1, 1'b0, a);
        check("divd_cls", 64'(busA.execClass_o), 64'd2);
        check("divd_unit", 64'(busA.functionalUnitCode_o), 64'd5);
        check("divd32_valid", 64'(busB.valid_o), 64'd0);
        check("divd32_unrec", 64'(unB), 64'd1);
        idle();
        check("divd32_unrec_once", 64'(unB), 64'd0);

        sent = 1;
        for (int cy = 0; cy < 30 && got.size() < 4; cy++) begin
            if (busA.valid_o && cy >= 3) got.push_back(busA.tag_o);
            step(sent <= 4, ADD, 8'(sent), cy >= 3, 1'b0, a);
            if (a) sent++;
            if (cy == 2) begin
                check("bp_ready_low", 64'(busA.ready_o), 64'd0);
                check("bp_accepted", 64'(sent - 1), 64'd2);
            end
        end
        check("bp_count", 64'(got.size()), 64'd4);
        foreach (got[k]) check($sformatf("bp_tag%0d", k), 64'(got[k]), 64'(k + 1));
        idle();

        step(1'b1, ADD, 8'h21, 1'b0, 1'b0, a);
        step(1'b1, ADD, 8'h22, 1'b0, 1'b0, a);
        check("full_ready", 64'(busA.ready_o), 64'd0);
        c0 = int'(cntA);
        step(1'b1, ADD, 8'h23, 1'b0, 1'b1, a);
        check("flush_valid", 64'(busA.valid_o), 64'd0);
        check("flush_ready", 64'(busA.ready_o), 64'd1);
        check("flush_cnt", 64'(cntA), 64'(c0));

        step(1'b1, ADD, 8'h31, 1'b0, 1'b0, a);
        step(1'b1, ADD, 8'h32, 1'b0, 1'b0, a);
        #2 rst = 1'b1;
        #1;
        check("arst_validA", 64'(busA.valid_o), 64'd0);
        check("arst_validB", 64'(busB.valid_o), 64'd0);
        check("arst_pktA", 64'(obsA), 64'd0);
        check("arst_unrec", 64'(unA), 64'd0);
        check("arst_cnt", 64'(cntA), 64'd0);
        check("arst_ready", 64'(busA.ready_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 17; i++) step(1'b1, ADD, 8'(i), 1'b1, 1'b0, a);
        idle();
        check("wrap_cnt4", 64'(cntB), 64'd1);
        check("wrap_cnt16", 64'(cntA), 64'd17);

        step(1'b1, 32'h38600001, 8'h41, 1'b1, 1'b0, a);
        check("addi_valid", 64'(busA.valid_o), 64'd0);
        check("addi_unrec", 64'(unA), 64'd0);
        idle();

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, rand_word(), 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xo_decode_stage.md
Name: xo_decode_stage

Overview:
- Pipelined successor to the single-cycle XO-form decoder. It sits between fetch/issue and dispatch.
- It decodes POWER ISA 3.0B XO-form instructions (primary opcode 31, 9-bit extended opcode in bits 22:30) into a registered decode packet. The packet adds operand-usage, carry and execution-class fields.
- Valid/ready handshakes on both sides, with a 2-entry skid buffer, so it sustains 1 instruction/cycle under downstream back-pressure.
- Adds a 32/64-bit mode, flush, an unrecognised-opcode report and a decode counter.

Parameters:
- instructionWidth, 32, instruction word width (bit 0 = MSB, ISA numbering)
- regWidth, 5, register specifier width
- XoOpCodeWidth, 9, extended opcode width
- tagWidth, 8, opaque instruction tag passed through unchanged
- countWidth, 16, width of decoded-instruction counter
- support64, 1, 1 = doubleword ops legal; 0 = doubleword ops reported as unrecognised
- FXUnitCode, 0, functional unit code for add/sub/BCD
- MulDivUnitCode, 5, functional unit code for multiply/divide

Ports:
- clock_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous flush; discards all buffered packets
- valid_i  in  1  upstream instruction valid
- ready_o  out  1  stage can accept an instruction this cycle
- instruction_i  in  instructionWidth  instruction word
- tag_i  in  tagWidth  instruction tag
- valid_o  out  1  decode packet valid
- ready_i  in  1  downstream accepts packet
- tag_o  out  tagWidth  passed-through tag
- reg1_o, reg2_o, reg3_o  out  regWidth  RT, RA, RB (bits 6:10, 11:15, 16:20)
- xOpCode_o  out  XoOpCodeWidth  bits 22:30
- oe_o  out  1  bit 21; forced 0 for mulhw/mulhwu/mulhd/mulhdu/addg6s
- rc_o  out  1  bit 31; forced 0 for addg6s
- useRb_o  out  1  RB is a source operand
- readsCa_o  out  1  consumes XER[CA]
- writesCa_o  out  1  produces XER[CA]
- execClass_o  out  2  0 = add/sub, 1 = multiply, 2 = divide, 3 = BCD
- functionalUnitCode_o  out  3  dispatch unit code
- unrecognised_o  out  1  1-cycle pulse: accepted opcode-31 word matched no XO entry
- decodeCount_o  out  countWidth  number of packets emitted

Behaviour:
- Reset (async) clears the following to 0: both buffer entries, valid_o, unrecognised_o, decodeCount_o and all packet fields. ready_o = 1 after reset.
- Acceptance: a beat is accepted when valid_i && ready_o. ready_o = !skidValid, registered.
- Accepted beats with primary opcode != 31 are consumed and dropped: no packet, no pulse.
- Opcode table, add/sub class (FXUnitCode):
  - 266, 40, 10, 8, 138, 136: useRb = 1
  - 234, 232, 202, 200, 104: useRb = 0
  - readsCa = 1 for 138, 136, 234, 232, 202, 200
  - writesCa = 1 for the readsCa set plus 10 and 8
- Multiply (MulDivUnitCode): 235, 75, 11, and doubleword 233, 73, 9.
- Divide (MulDivUnitCode): 491, 459, 427, 395, and doubleword 489, 457, 425, 393.
- BCD: 74 (addg6s), FXUnitCode.
- Multiply, divide and BCD entries all have useRb = 1 and readsCa = writesCa = 0.
- Doubleword ops with support64 = 0 are treated as unrecognised.
- Unrecognised: no packet is produced. unrecognised_o pulses high the cycle after acceptance.
- Latency: 1 cycle from acceptance to valid_o when the output register is empty or draining.
- Skid buffer:
  - The output register holds the current packet; the skid register catches one packet when the output is stalled.
  - Output register loads when (!valid_o || ready_i). Source is the skid entry if skidValid, else the new decode.
  - New decode goes to skid when valid_o && !ready_i. ready_o then falls the next cycle.
  - Packets leave in acceptance order. A packet is held stable while valid_o && !ready_i.
- decodeCount_o increments on each valid_o && ready_i handshake and wraps modulo 2^countWidth.
- flush_i:
  - Clears valid_o, skidValid and any same-cycle acceptance; ready_o = 1 the next cycle.
  - Counter is not cleared. flush_i has priority over simultaneous accept/emit, and a packet handshaken in the flush cycle still counts.
- Reset asserted mid-stall discards buffered packets immediately (async).

Test Plan:
- Reset, then 0x7C642A14 (add r3,r4,r5) with ready_i = 1 → next cycle: valid_o = 1, reg = 3/4/5, xOpCode_o = 266, execClass_o = 0, useRb_o = 1, writesCa_o = 0, decodeCount_o = 1 one cycle later.
- 0x7CC70195 (addze. r6,r7) → rc_o = 1, useRb_o = 0, readsCa_o = writesCa_o = 1, FXUnitCode.
- 0x7C2213D2 (divd r1,r2,r3): with support64 = 1 → execClass_o = 2, unit 5; with support64 = 0 → no valid_o, unrecognised_o pulses once.
- Back-pressure: stream 4 tagged adds (tags 1..4), hold ready_i = 0 for 3 cycles → ready_o drops after 2 accepted; release → tags emerge 1, 2, 3, 4 in order with no loss or duplication.
- Assert flush_i with both entries full → valid_o = 0, ready_o = 1 next cycle, decodeCount_o unchanged. Assert reset_i mid-stream → all outputs 0 immediately.
- Non-31 word 0x38600001 (addi) accepted → no packet and no unrecognised_o; countWidth = 4 with 17 emits → decodeCount_o = 1.
